binary_to_tc_9_stream: RTL and testbench
========================================

Name: binary_to_tc_9_stream

Overview:
- Streaming encoder from 4-bit binary residue (mod 9, values 0..8) to 8-bit thermometer code (TC-9) for the RNS mod-9 channel.
- Inverse of the TC-9-to-binary decoder: feeds binary-domain residues into the thermometer-coded modulo adder datapath.
- Valid/ready on both sides, 2-entry output buffer for full throughput under backpressure, sticky saturating count of illegal inputs.

Parameters:
- ERR_CNT_W, 8, width of illegal-input counter (saturating).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  in_bin valid
- in_ready  output  1  block can accept in_bin this cycle
- in_bin  input  4  binary residue; legal 0..8
- out_valid  output  1  out_tc/out_err valid
- out_ready  input  1  consumer accepts current output
- out_tc  output  8  thermometer code, bit 1 = LSB
- out_err  output  1  current output came from illegal in_bin (9..15)
- err_cnt  output  ERR_CNT_W  count of accepted illegal inputs, saturating
- clr_err  input  1  synchronous clear of err_cnt

Behaviour:
- Encoding: in_bin = k (0..8) -> out_tc = lowest k bits set, rest 0 (0->8'h00, 1->8'h01, 3->8'h07, 8->8'hFF); out_err=0.
- Illegal in_bin 9..15 -> out_tc=8'h00, out_err=1; still accepted and passed through as a normal entry.
- Input accept: transfer when in_valid && in_ready at rising edge.
- Output transfer: when out_valid && out_ready at rising edge.
- Storage: 2-entry FIFO of {out_tc, out_err}; head drives out_tc/out_err; occupancy count 0..2.
- in_ready = (count < 2) && !rst; depends only on registered state, never on out_ready.
- Latency: entry accepted at edge N is visible with out_valid=1 immediately after edge N when the FIFO was empty; otherwise after preceding entries drain.
- Throughput: one word/cycle sustained when out_ready held 1.
- Simultaneous push and pop, count 1: count stays 1, head replaced by new entry.
- Simultaneous push and pop, count 2: not possible, since in_ready=0.
- Simultaneous push and pop, count 0: push only; pop not possible since out_valid=0.
- Stability: while out_valid && !out_ready, out_tc/out_err hold; order preserved (FIFO).
- out_valid = (count != 0).
- err_cnt: +1 per accepted illegal input; saturates at 2^ERR_CNT_W-1; clr_err=1 forces 0 next edge.
- clr_err has priority over a same-cycle increment.
- Reset, asynchronous: count=0, both entries=0, out_valid=0, out_tc=8'h00, out_err=0, err_cnt=0, in_ready=0 while rst=1.
- Mid-stream reset discards buffered entries with no output transfer; in_ready=1 on first edge after release.
- X on in_bin while in_valid=0 is ignored; stored state is never corrupted.

Test Plan:
- Reset, then in_bin 0..8 in consecutive cycles, out_ready=1 -> out_tc sequence 00,01,03,07,0F,1F,3F,7F,FF, one per cycle, 1-cycle latency, out_err=0 throughout, err_cnt=0.
- Backpressure: out_ready=0, push 5 then 2 -> in_ready falls after 2nd accept; out_tc holds 8'h1F. Raise out_ready: 8'h1F then 8'h03 delivered, in_ready=1 after first pop.
- Illegal inputs: push 9, 15, 4 -> outputs {00,err=1},{00,err=1},{0F,err=0}; err_cnt=2. Pulse clr_err -> err_cnt=0.
- Saturation: ERR_CNT_W=2, push 12 five times -> err_cnt ends at 3. clr_err concurrent with illegal accept -> err_cnt=0.
- Simultaneous push/pop at count=1: random valid/ready toggling for 1000 cycles -> output stream equals input stream mapped by encoding, in order, no loss or duplication.
- Async reset asserted mid-cycle with 2 entries buffered -> out_valid=0 and in_ready=0 immediately. After release, first push of 6 -> out_tc=8'h3F.

Source files
------------

// File: rtl/binary_to_tc_9_stream_if.sv
// Valid/ready stream bundle for the mod-9 binary to thermometer-code encoder:
// binary residue in, 8-bit thermometer code plus illegal-input flag out.
interface binary_to_tc_9_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_tc;
    logic       out_err;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_tc, out_err
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_tc, out_err
    );
endinterface

// File: rtl/binary_to_tc_9_stream.sv
// Streaming mod-9 residue encoder: binary 0..8 to TC-9 thermometer code, with a
// 2-entry output FIFO and a sticky saturating count of illegal inputs.
module binary_to_tc_9_stream #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    binary_to_tc_9_stream_if.slave     bus,
    output logic [ERR_CNT_W-1:0]       err_cnt,
    input  logic                       clr_err
);

    typedef struct packed {
        logic       err;
        logic [7:0] tc;
    } entry_t;

    // Residues 9..15 are not valid mod-9 values: flag them and emit an all-zero code.
    function automatic entry_t encode(input logic [3:0] bin);
        entry_t e;
        e.err = 1'b0;
        e.tc  = 8'h00;
        if (bin <= 4'd8) begin
            for (int i = 0; i < 8; i++) begin
                e.tc[i] = (bin > 4'(i));
            end
        end else begin
            e.err = 1'b1;
        end
        return e;
    endfunction

    entry_t                 head_r, tail_r, head_n, tail_n, new_s;
    logic [1:0]             count_r, count_n;
    logic [ERR_CNT_W-1:0]   err_cnt_r, err_cnt_n;
    logic                   in_ready_s, push_s, pop_s;

    // Handshake decode; readiness depends only on stored occupancy.
    always_comb begin
        in_ready_s = (count_r < 2'd2) && !rst;
        push_s     = bus.in_valid && in_ready_s;
        pop_s      = (count_r != 2'd0) && bus.out_ready;
        new_s      = encode(bus.in_bin);
    end

    // FIFO and error-counter next state.
    always_comb begin
        head_n    = head_r;
        tail_n    = tail_r;
        count_n   = count_r;
        err_cnt_n = err_cnt_r;
        if (push_s && pop_s) begin
            // Only reachable with one entry held: the new word becomes the head.
            head_n = new_s;
        end else if (push_s) begin
            if (count_r == 2'd0) begin
                head_n = new_s;
            end else begin
                tail_n = new_s;
            end
            count_n = count_r + 2'd1;
        end else if (pop_s) begin
            head_n  = tail_r;
            tail_n  = '0;
            count_n = count_r - 2'd1;
        end else begin
            count_n = count_r;
        end

        if (clr_err) begin
            err_cnt_n = '0;
        end else if (push_s && new_s.err && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_n = err_cnt_r + ERR_CNT_W'(1);
        end else begin
            err_cnt_n = err_cnt_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r    <= '0;
            tail_r    <= '0;
            count_r   <= 2'd0;
            err_cnt_r <= '0;
        end else begin
            head_r    <= head_n;
            tail_r    <= tail_n;
            count_r   <= count_n;
            err_cnt_r <= err_cnt_n;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (count_r != 2'd0);
    assign bus.out_tc    = head_r.tc;
    assign bus.out_err   = head_r.err;
    assign err_cnt       = err_cnt_r;

endmodule

// File: tb/tb_binary_to_tc_9_stream.sv
// Bench for binary_to_tc_9_stream: queue-based reference model, vector table,
// directed corner sequences and randomized valid/ready traffic.
module tb_binary_to_tc_9_stream;

    logic       clk;
    logic       rst;
    logic       clr_a, clr_b;
    logic [7:0] err_a;
    logic [1:0] err_b;

    binary_to_tc_9_stream_if ia ();
    binary_to_tc_9_stream_if ib ();

    binary_to_tc_9_stream #(.ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave), .err_cnt(err_a), .clr_err(clr_a)
    );
    binary_to_tc_9_stream #(.ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave), .err_cnt(err_b), .clr_err(clr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tc;
        logic       err;
    } word_t;

    typedef struct {
        logic [3:0] bin;
        logic [7:0] tc;
        logic       err;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    word_t      q[$];
    int         errs = 0;
    logic [7:0] therm [9];
    vec_t       tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic word_t model_enc(input logic [3:0] b);
        word_t w;
        if (b < 4'd9) begin
            w.tc  = therm[b];
            w.err = 1'b0;
        end else begin
            w.tc  = 8'h00;
            w.err = 1'b1;
        end
        return w;
    endfunction

    // One clock of DUT A: drive at negedge, compare against model, advance model.
    task automatic step(input logic iv, input logic [3:0] b, input logic ordy, input logic clr);
        bit    push, pop;
        word_t w;
        @(negedge clk);
        ia.in_valid  = iv;
        ia.in_bin    = b;
        ia.out_ready = ordy;
        clr_a        = clr;
        chk("out_valid", 32'(ia.out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(ia.in_ready), 32'(q.size() < 2));
        if (q.size() != 0) begin
            chk("out_tc", 32'(ia.out_tc), 32'(q[0].tc));
            chk("out_err", 32'(ia.out_err), 32'(q[0].err));
        end
        chk("err_cnt", 32'(err_a), 32'(errs));
        push = iv && (q.size() < 2);
        pop  = ordy && (q.size() != 0);
        if (pop) void'(q.pop_front());
        if (push) begin
            w = model_enc(b);
            q.push_back(w);
        end
        if (clr) errs = 0;
        else if (push && w.err && errs < 255) errs = errs + 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        therm = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        tbl = '{
            '{4'd0, 8'h00, 1'b0}, '{4'd1, 8'h01, 1'b0}, '{4'd2, 8'h03, 1'b0},
            '{4'd3, 8'h07, 1'b0}, '{4'd4, 8'h0F, 1'b0}, '{4'd5, 8'h1F, 1'b0},
            '{4'd6, 8'h3F, 1'b0}, '{4'd7, 8'h7F, 1'b0}, '{4'd8, 8'hFF, 1'b0},
            '{4'd9, 8'h00, 1'b1}, '{4'd12, 8'h00, 1'b1}, '{4'd15, 8'h00, 1'b1}
        };
        rst = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        ia.in_valid = 1'b0; ia.in_bin = 4'd0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_bin = 4'd0; ib.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("rst_in_ready", 32'(ia.in_ready), 32'd0);
        chk("rst_out_tc", 32'(ia.out_tc), 32'd0);
        chk("rst_out_err", 32'(ia.out_err), 32'd0);
        chk("rst_err_cnt", 32'(err_a), 32'd0);
        rst = 1'b0;

        // Back-to-back encoding with 1-cycle latency.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i].bin, 1'b1, 1'b0);
            chk("tbl_tc", 32'(ia.out_tc), 32'(tbl[i].tc));
            chk("tbl_err", 32'(ia.out_err), 32'(tbl[i].err));
        end
        step(1'b0, 4'bx, 1'b1, 1'b0);
        chk("tbl_err_cnt", 32'(err_a), 32'd3);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        chk("tbl_clr", 32'(err_a), 32'd0);

        // Backpressure: fill both entries, hold, then drain.
        step(1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        chk("bp_in_ready_low", 32'(ia.in_ready), 32'd0);
        chk("bp_hold_tc", 32'(ia.out_tc), 32'h1F);
        step(1'b1, 4'd7, 1'b0, 1'b0);
        chk("bp_still_tc", 32'(ia.out_tc), 32'h1F);
        step(1'b0, 4'bx, 1'b1, 1'b0);
        chk("bp_in_ready_up", 32'(ia.in_ready), 32'd1);
        chk("bp_second_tc", 32'(ia.out_tc), 32'h03);
        step(1'b0, 4'bx, 1'b1, 1'b0);
        step(1'b0, 4'bx, 1'b1, 1'b0);

        // Illegal inputs and counter clear.
        step(1'b1, 4'd9, 1'b1, 1'b0);
        step(1'b1, 4'd15, 1'b1, 1'b0);
        step(1'b1, 4'd4, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("ill_err_cnt", 32'(err_a), 32'd2);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        chk("ill_clr", 32'(err_a), 32'd0);

        // Saturation on the 2-bit counter instance.
        @(negedge clk);
        ib.in_valid = 1'b1; ib.in_bin = 4'd12;
        repeat (5) @(posedge clk);
        @(negedge clk);
        ib.in_valid = 1'b0;
        chk("sat_err_cnt", 32'(err_b), 32'd3);
        chk("sat_out_err", 32'(ib.out_err), 32'd1);
        @(negedge clk);
        ib.in_valid = 1'b1; clr_b = 1'b1;
        @(negedge clk);
        ib.in_valid = 1'b0; clr_b = 1'b0;
        chk("sat_clr_prio", 32'(err_b), 32'd0);

        // Random traffic against the queue model.
        for (int i = 0; i < 1000; i++) begin
            logic iv;
            iv = ($urandom_range(0, 3) != 0);
            step(iv, iv ? 4'($urandom_range(0, 15)) : 4'bx,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        // Asynchronous reset with two entries buffered.
        step(1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd8, 1'b0, 1'b0);
        chk("pre_rst_full", 32'(ia.in_ready), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("arst_in_ready", 32'(ia.in_ready), 32'd0);
        chk("arst_out_tc", 32'(ia.out_tc), 32'd0);
        chk("arst_err_cnt", 32'(err_a), 32'd0);
        q.delete();
        errs = 0;
        @(negedge clk);
        rst = 1'b0;
        ia.in_valid = 1'b0;
        step(1'b1, 4'd6, 1'b1, 1'b0);
        chk("post_rst_tc", 32'(ia.out_tc), 32'h3F);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
